lfsr_keystream_ctrl: RTL and testbench

//  Sequencer wrapping one LFSR core into a keystream generator for the stream-cipher examples.
//  - Latches seed and polynomial on start, loads the core and runs a programmable warm-up.
//  - Then packs shifted-out bits into OUT_W-bit words on a valid/ready stream to the XOR/cipher stage.

---
 rtl/lfsr_ctrl_pkg.sv | 20 ++
 rtl/lfsr_keystream_ctrl_if.sv | 34 +++
 rtl/LFSR.sv | 33 +++
 rtl/lfsr_keystream_ctrl.sv | 125 ++++++++++++
 tb/tb_lfsr_keystream_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg: shared state encoding and counter widths for the keystream sequencer.
// Rev 1.0
`default_nettype none

package lfsr_ctrl_pkg;

  localparam int WARMUP_CNT_W = 16;
  localparam int KS_CNT_W     = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WARMUP = 3'd2,
    GEN    = 3'd3,
    HOLD   = 3'd4
  } state_t;

endpackage

`default_nettype wire

// File: rtl/lfsr_keystream_ctrl_if.sv
// lfsr_keystream_ctrl_if: session control and keystream valid/ready bundle.
// Rev 1.0
`default_nettype none

interface lfsr_keystream_ctrl_if
  import lfsr_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int OUT_W      = 8
);
  logic                    start;
  logic                    stop;
  logic [DATA_WIDTH-1:0]   seed;
  logic [DATA_WIDTH:0]     poly;
  logic [WARMUP_CNT_W-1:0] warmup_len;
  logic                    ks_ready;
  logic                    ks_valid;
  logic [OUT_W-1:0]        ks_data;
  logic                    busy;
  logic                    seed_err;
  logic [KS_CNT_W-1:0]     ks_count;

  modport master (
    output start, stop, seed, poly, warmup_len, ks_ready,
    input  ks_valid, ks_data, busy, seed_err, ks_count
  );

  modport slave (
    input  start, stop, seed, poly, warmup_len, ks_ready,
    output ks_valid, ks_data, busy, seed_err, ks_count
  );
endinterface

`default_nettype wire

// File: rtl/LFSR.sv
// LFSR: Fibonacci core, shifts left; bit DATA_WIDTH-1 leaves, feedback enters at bit 0.
// Rev 1.0
`default_nettype none

module LFSR #(
  parameter int DATA_WIDTH = 6
) (
  input  wire logic                  clk,
  input  wire logic                  rst,
  input  wire logic                  shift,
  input  wire logic [DATA_WIDTH:0]   feedback_coeff,
  input  wire logic [DATA_WIDTH-1:0] initial_state,
  output logic      [DATA_WIDTH-1:0] state
);

  logic w_fb;
  logic w_unused_coeff0;

  // coefficient i (x^i) taps state bit i-1; the constant term is implicit
  assign w_fb            = ^(state & feedback_coeff[DATA_WIDTH:1]);
  assign w_unused_coeff0 = feedback_coeff[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= initial_state;
    end else if (shift) begin
      state <= {state[DATA_WIDTH-2:0], w_fb};
    end
  end

endmodule

`default_nettype wire

// File: rtl/lfsr_keystream_ctrl.sv
// lfsr_keystream_ctrl: loads an LFSR core, runs a warm-up, then packs output bits into words.
// Rev 1.0
`default_nettype none

module lfsr_keystream_ctrl
  import lfsr_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int OUT_W      = 8
) (
  input wire logic              clk,
  input wire logic              rst,
  lfsr_keystream_ctrl_if.slave  bus
);

  localparam int                BCNT_W     = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [BCNT_W-1:0] C_BIT_LAST = BCNT_W'(OUT_W - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [DATA_WIDTH-1:0]   r_seed;
  logic [DATA_WIDTH:0]     r_poly;
  logic [WARMUP_CNT_W-1:0] r_wcnt;
  logic [BCNT_W-1:0]       r_bcnt;
  logic [OUT_W-1:0]        r_pack;
  logic [OUT_W-1:0]        r_data;
  logic [KS_CNT_W-1:0]     r_count;
  logic                    r_seed_err;

  logic                    w_start_ok;
  logic                    w_load;
  logic                    w_shift;
  logic                    w_last;
  logic                    w_xfer;
  logic                    w_core_rst;
  logic                    w_bit;
  logic [OUT_W-1:0]        w_pack_next;
  logic [DATA_WIDTH-1:0]   w_core_state;

  assign w_start_ok  = (r_state == IDLE) && bus.start && (bus.seed != '0);
  assign w_last      = (r_state == GEN) && (r_bcnt == C_BIT_LAST);
  assign w_xfer      = (r_state == HOLD) && bus.ks_ready;
  assign w_bit       = w_core_state[DATA_WIDTH-1];
  assign w_pack_next = (r_pack << 1) | OUT_W'(w_bit);
  assign w_core_rst  = rst | w_load;

  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    unique case (r_state)
      IDLE:    if (w_start_ok) w_next = LOAD;
      LOAD: begin
        w_load = 1'b1;
        w_next = (r_wcnt == '0) ? GEN : WARMUP;
      end
      WARMUP: begin
        w_shift = 1'b1;
        if (r_wcnt == WARMUP_CNT_W'(1)) w_next = GEN;
      end
      GEN: begin
        w_shift = 1'b1;
        if (w_last) w_next = HOLD;
      end
      HOLD:    if (bus.ks_ready) w_next = GEN;
      default: w_next = IDLE;
    endcase
    // stop wins over every transition, but a HOLD transfer in the same cycle still counts
    if (r_state != IDLE && bus.stop) w_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_seed     <= '0;
      r_poly     <= '0;
      r_wcnt     <= '0;
      r_bcnt     <= '0;
      r_pack     <= '0;
      r_data     <= '0;
      r_count    <= '0;
      r_seed_err <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_seed_err <= (r_state == IDLE) && bus.start && (bus.seed == '0);
      if (w_start_ok) begin
        r_seed  <= bus.seed;
        r_poly  <= bus.poly;
        r_wcnt  <= bus.warmup_len;
        r_count <= '0;
      end
      if (r_state == LOAD) begin
        r_bcnt <= '0;
        r_pack <= '0;
      end
      if (r_state == WARMUP) r_wcnt <= r_wcnt - WARMUP_CNT_W'(1);
      if (r_state == GEN) begin
        r_bcnt <= w_last ? '0 : r_bcnt + BCNT_W'(1);
        r_pack <= w_pack_next;
        if (w_last) r_data <= w_pack_next;
      end
      if (w_xfer) r_count <= r_count + KS_CNT_W'(1);
    end
  end

  LFSR #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_core (
    .clk            (clk),
    .rst            (w_core_rst),
    .shift          (w_shift),
    .feedback_coeff (r_poly),
    .initial_state  (r_seed),
    .state          (w_core_state)
  );

  assign bus.ks_valid = (r_state == HOLD);
  assign bus.ks_data  = r_data;
  assign bus.busy     = (r_state != IDLE);
  assign bus.seed_err = r_seed_err;
  assign bus.ks_count = r_count;

endmodule

`default_nettype wire

// File: tb/tb_lfsr_keystream_ctrl.sv
// tb_lfsr_keystream_ctrl: vector table plus directed sequences against a software LFSR model.
// Rev 1.0
`default_nettype none

module tb_lfsr_keystream_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;
  int   cyc;

  lfsr_keystream_ctrl_if #(.DATA_WIDTH(6), .OUT_W(8)) bus ();

  lfsr_keystream_ctrl #(.DATA_WIDTH(6), .OUT_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  seed;
    logic [6:0]  poly;
    logic [15:0] warmup;
    int          nwords;
    int          exp_first;
    bit          chk_const;
    logic [7:0]  word0;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] sb [$];

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: x^i coefficient feeds back state bit i-1, output is the top bit before the shift
  function automatic logic [7:0] model_word(input logic [5:0] seed, input logic [6:0] poly,
                                            input int first);
    logic [5:0] s;
    logic [7:0] w;
    logic       fb;
    s = seed;
    w = 8'h00;
    for (int t = 0; t < first + 8; t++) begin
      if (t >= first) w = {w[6:0], s[5]};
      fb = 1'b0;
      for (int i = 1; i <= 6; i++) if (poly[i]) fb = fb ^ s[i-1];
      s = {s[4:0], fb};
    end
    return w;
  endfunction

  task automatic run_vec(input vec_t v, input bit perturb);
    int         first;
    int         last;
    int         done;
    logic [7:0] exp;
    sb.delete();
    for (int k = 0; k < v.nwords; k++) sb.push_back(model_word(v.seed, v.poly, int'(v.warmup) + 8 * k));
    bus.seed       = v.seed;
    bus.poly       = v.poly;
    bus.warmup_len = v.warmup;
    bus.ks_ready   = 1'b1;
    bus.start      = 1'b1;
    tick();
    bus.start = 1'b0;
    if (perturb) begin
      bus.seed       = 6'b101010;
      bus.poly       = 7'b1000010;
      bus.warmup_len = 16'd9;
      bus.start      = 1'b1;
    end
    first = -1;
    last  = -1;
    done  = 0;
    for (int c = 1; c < 200 && done < v.nwords; c++) begin
      if (bus.ks_valid) begin
        if (first < 0) first = c;
        if (bus.ks_ready) begin
          exp = sb.pop_front();
          chk("ks_data", bus.ks_data, exp);
          if (done == 0 && v.chk_const) chk("ks_data_const", bus.ks_data, v.word0);
          done++;
          last = c;
        end
      end
      tick();
    end
    bus.start = 1'b0;
    chk("first_valid_cycle", first, v.exp_first);
    chk("last_word_cycle", last, v.exp_first + (v.nwords - 1) * 9);
    chk("ks_count", bus.ks_count, v.nwords);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("busy_after_stop", bus.busy, 0);
  endtask

  initial begin
    int         c;
    int         n;
    logic [7:0] hold;
    logic [31:0] cnt_before;
    bit         seen_valid;
    n_cmp = 0;
    n_bad = 0;
    cyc   = 0;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.seed       = '0;
    bus.poly       = '0;
    bus.warmup_len = '0;
    bus.ks_ready   = 1'b0;

    vecs[0] = '{6'b000001, 7'b1100000, 16'd0,  3, 10, 1'b1, 8'h04};
    vecs[1] = '{6'b000001, 7'b1100000, 16'd5,  2, 15, 1'b0, 8'h00};
    vecs[2] = '{6'b101101, 7'b1100000, 16'd3,  2, 13, 1'b0, 8'h00};
    vecs[3] = '{6'b110011, 7'b1000010, 16'd0,  2, 10, 1'b0, 8'h00};
    vecs[4] = '{6'b111111, 7'b1100000, 16'd17, 1, 27, 1'b0, 8'h00};

    repeat (3) tick();
    rst = 1'b0;
    chk("rst_busy", bus.busy, 0);
    chk("rst_valid", bus.ks_valid, 0);
    chk("rst_data", bus.ks_data, 0);
    chk("rst_seed_err", bus.seed_err, 0);
    chk("rst_count", bus.ks_count, 0);

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 1'b0);

    // Backpressure, then stop together with a handshake in HOLD
    bus.seed = 6'b000001; bus.poly = 7'b1100000; bus.warmup_len = 16'd0;
    bus.ks_ready = 1'b0; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    c = 1;
    while (!bus.ks_valid && c < 50) begin tick(); c++; end
    chk("bp_first_valid", c, 10);
    hold = bus.ks_data;
    chk("bp_word0", hold, 8'h04);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid_hold", bus.ks_valid, 1);
      chk("bp_data_hold", bus.ks_data, hold);
    end
    bus.ks_ready = 1'b1;
    tick();
    chk("bp_count1", bus.ks_count, 1);
    n = 1;
    while (!bus.ks_valid && n < 30) begin tick(); n++; end
    chk("bp_gap", n, 9);
    chk("bp_word1", bus.ks_data, model_word(6'b000001, 7'b1100000, 8));
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_hold_count", bus.ks_count, 2);
    chk("stop_hold_busy", bus.busy, 0);
    chk("stop_hold_valid", bus.ks_valid, 0);

    // Zero seed is rejected
    cnt_before = bus.ks_count;
    bus.seed = 6'b000000; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("seed_err_pulse", bus.seed_err, 1);
    chk("seed_err_busy", bus.busy, 0);
    tick();
    chk("seed_err_end", bus.seed_err, 0);
    chk("seed_err_busy2", bus.busy, 0);
    chk("seed_err_count", bus.ks_count, cnt_before);

    // Stop in the middle of GEN
    bus.seed = 6'b101101; bus.poly = 7'b1100000; bus.warmup_len = 16'd0;
    bus.ks_ready = 1'b1; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("gen_busy", bus.busy, 1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    chk("stop_gen_busy", bus.busy, 0);
    chk("stop_gen_valid", bus.ks_valid, 0);
    seen_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (bus.ks_valid) seen_valid = 1'b1;
    end
    chk("stop_gen_no_valid", seen_valid, 0);
    chk("stop_gen_count", bus.ks_count, 0);

    // Reset in the middle of WARMUP
    bus.seed = 6'b000001; bus.warmup_len = 16'd20; bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (4) tick();
    chk("warmup_busy", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_valid", bus.ks_valid, 0);
    chk("midrst_data", bus.ks_data, 0);
    chk("midrst_count", bus.ks_count, 0);
    chk("midrst_seed_err", bus.seed_err, 0);

    // Inputs change and start is held while a session runs
    run_vec('{6'b000001, 7'b1100000, 16'd2, 2, 12, 1'b0, 8'h00}, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
